ps_link_sched: RTL and testbench
================================

// Module: ps_link_sched
// PURPOSE
//  Scheduler/controller in front of the parallel-to-serial converter, clocked by clk_8f.
//  Shares one serial byte lane between two byte requesters, generates the 1-in-RATIO
//  byte-load strobe, and runs link training by sending comma symbols after reset.
//  Sends idle commas whenever neither requester has data.
// PARAMETERS
//  RATIO       8      clk_8f cycles per byte slot (serializer ratio); power of 2, >=2
//  COMMA       8'hBC  idle/training symbol placed on ser_data when ser_valid=0
//  TRAIN_SYMS  4      number of comma slots sent after reset before RUN; >=1
// PORTS
//  clk_8f      in   1  single clock, all logic on posedge
//  reset       in   1  synchronous, active-high
//  req0_valid  in   1  requester 0 has a byte
//  req0_data   in   8  requester 0 byte
//  req0_ready  out  1  requester 0 byte consumed this cycle (valid&&ready = transfer)
//  req1_valid  in   1  requester 1 has a byte
//  req1_data   in   8  requester 1 byte
//  req1_ready  out  1  requester 1 byte consumed this cycle
//  ser_load    out  1  1-cycle pulse: serializer latches ser_data/ser_valid
//  ser_data    out  8  byte for current slot (COMMA when idle/training)
//  ser_valid   out  1  ser_data carries requester data
//  grant       out  2  one-hot owner of current slot, 2'b00 when idle/training
//  active      out  1  link in RUN state
// BEHAVIOUR
//  Reset values: ser_load=0 ser_data=8'h00 ser_valid=0 grant=2'b00 active=0 reqX_ready=0;
//   phase=0, state=TRAIN, train_cnt=0, rr_last=1 (req0 wins the first tie).
//  phase: counter 0..RATIO-1, +1 every cycle, wraps; wrap edge = slot boundary.
//   Reset released at cycle 0 -> boundaries at cycles RATIO, 2*RATIO, ...
//  At each boundary, registered outputs update together: ser_load=1 for exactly the
//   phase==0 cycle, otherwise 0.
//  States:
//   TRAIN: each boundary sends ser_data=COMMA, ser_valid=0, grant=0; train_cnt++.
//          After the TRAIN_SYMS-th boundary go to RUN (active=1 from the next cycle).
//          Defaults: commas at cycles 8,16,24,32; first data slot at cycle 40.
//   RUN:   stays until reset. On the phase==RATIO-1 cycle, pick a winner from the
//          current valids. Drive reqW_ready=1 combinationally in that cycle only.
//          At the boundary: ser_data=reqW_data, ser_valid=1, grant=onehot(W).
//          No valid -> ser_data=COMMA, ser_valid=0, grant=0.
//  ready is never asserted outside phase==RATIO-1 in RUN, and at most one ready per cycle.
//  Valid dropping before phase RATIO-1 is legal; no transfer for that requester.
//  Latency: byte accepted on phase RATIO-1 appears on ser_data on the next cycle (phase 0).
//  Outputs ser_data/ser_valid/grant hold between boundaries.
//  Reset mid-slot/mid-RUN: all state returns to reset values and TRAIN restarts.
//   No byte is lost: ready was never given for an unsent byte.
// CONFIGURATION
//  RR_FAIR_EN defined: round-robin. On a tie, grant the requester != rr_last.
//   rr_last updates only on a grant; a lone valid requester always wins.
//  RR_FAIR_EN undefined: fixed priority, req0 always wins ties; rr_last logic absent.
// STRUCTURE
//  ps_link_defs.vh: state encodings (ST_TRAIN=1'b0, ST_RUN=1'b1), default COMMA,
//   RATIO, TRAIN_SYMS localparams; shared with deserializer-side blocks.
//  Sub-module ps_phase_cnt: phase counter with sync reset, outputs last_phase (phase==RATIO-1)
//   and wrap pulse. Arbitration and FSM stay in ps_link_sched.
// TESTING
//  1 Reset held 5 cycles, then released, no valids -> ser_load pulses at 8,16,24,32,40;
//    ser_data=BC, ser_valid=0, active=1 from cycle 33.
//  2 RUN, req0_valid=1 with data 11 then FF -> req0_ready at cycles 39 and 47;
//    ser_data=11 at 40, FF at 48, ser_valid=1, grant=01.
//  3 Both valid (req0=EE, req1=4E) across 4 slots, RR_FAIR_EN -> slot order EE,4E,EE,4E;
//    without the macro, EE in every slot and req1_ready never asserts.
//  4 req1_valid=1 (data A2) only during phases 0..5, dropped at 6 -> no ready;
//    slot sends BC, ser_valid=0.
//  5 reset at phase 3 of a data slot -> next cycle all outputs at reset values;
//    training restarts with 4 commas; held byte 90 is sent at the 5th boundary after release.
//  6 Check every cycle: ser_load period == RATIO, |{req0_ready,req1_ready}|<=1,
//    ready only at phase RATIO-1.

Source files
------------

// File: rtl/ps_link_sched_pkg.sv
// ps_link_sched_pkg
//   Shared definitions for the parallel-to-serial link scheduler and the
//   deserializer-side blocks: link state encodings, default slot ratio,
//   comma symbol and training length, and the grant encoding helper.
//   No ports (package).
package ps_link_sched_pkg;

    localparam int         BYTE_W         = 8;
    localparam int         RATIO_DEF      = 8;
    localparam logic [7:0] COMMA_DEF      = 8'hBC;
    localparam int         TRAIN_SYMS_DEF = 4;

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } link_state_t;

    typedef logic [1:0] grant_t;

    // Slot owner as one-hot {req1, req0}; 2'b00 means idle/training slot.
    function automatic grant_t grant_onehot(input logic pick0, input logic pick1);
        return {pick1, pick0};
    endfunction

endpackage

// File: rtl/ps_link_sched_if.sv
// ps_link_sched_if
//   Byte-lane bundle between two requesters, the scheduler and the serializer.
//   Signals:
//     req0_valid/req0_data/req0_ready  requester 0 byte handshake
//     req1_valid/req1_data/req1_ready  requester 1 byte handshake
//     ser_load   1-cycle load strobe toward the serializer
//     ser_data   byte for the current slot (comma when idle/training)
//     ser_valid  ser_data carries requester data
//     grant      one-hot slot owner, 2'b00 when idle/training
//     active     link in RUN state
//   Modports: slave = scheduler side, master = requester/serializer side.
interface ps_link_sched_if;
    import ps_link_sched_pkg::*;

    logic              req0_valid;
    logic [BYTE_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [BYTE_W-1:0] req1_data;
    logic              req1_ready;
    logic              ser_load;
    logic [BYTE_W-1:0] ser_data;
    logic              ser_valid;
    grant_t            grant;
    logic              active;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, ser_load, ser_data, ser_valid, grant, active
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, ser_load, ser_data, ser_valid, grant, active
    );

endinterface

// File: rtl/ps_phase_cnt.sv
// ps_phase_cnt
//   Slot phase counter for the serial byte lane. Counts 0..RATIO-1 on every
//   clk_8f cycle and wraps; the wrap edge is the slot boundary.
//   Ports:
//     clk_8f      in   clock, all logic on posedge
//     reset       in   synchronous, active-high; phase returns to 0
//     last_phase  out  combinational, phase == RATIO-1 (slot decision cycle)
//     wrap        out  registered, high for the phase==0 cycle that follows
//                      a wraparound (low in the first slot after reset)
module ps_phase_cnt #(
    parameter int RATIO = 8
) (
    input  logic clk_8f,
    input  logic reset,
    output logic last_phase,
    output logic wrap
);

    localparam int PHASE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [PHASE_W-1:0] phase;

    assign last_phase = (phase == PHASE_W'(RATIO - 1));

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            phase <= '0;
            wrap  <= 1'b0;
        end else begin
            // RATIO is a power of two, so the natural rollover is the wrap.
            phase <= phase + PHASE_W'(1);
            wrap  <= last_phase;
        end
    end

endmodule

// File: rtl/ps_link_sched.sv
// ps_link_sched
//   Scheduler/controller in front of the parallel-to-serial converter.
//   Shares one serial byte lane between two requesters, issues the
//   1-in-RATIO byte-load strobe, and trains the link after reset by sending
//   TRAIN_SYMS comma slots before entering RUN. Idle slots carry COMMA.
//   Ports:
//     clk_8f  in   clock, all logic on posedge
//     reset   in   synchronous, active-high
//     bus     slave modport of ps_link_sched_if (requester handshakes,
//             ser_load/ser_data/ser_valid, grant, active)
//   Build option:
//     RR_FAIR_EN  defined   -> round-robin between requesters on a tie
//                 undefined -> fixed priority, requester 0 wins ties
module ps_link_sched
    import ps_link_sched_pkg::*;
#(
    parameter int         RATIO      = RATIO_DEF,
    parameter logic [7:0] COMMA      = COMMA_DEF,
    parameter int         TRAIN_SYMS = TRAIN_SYMS_DEF
) (
    input  logic             clk_8f,
    input  logic             reset,
    ps_link_sched_if.slave   bus
);

    localparam int CNT_W = $clog2(TRAIN_SYMS + 1);

    logic              last_phase;
    logic              wrap;
    link_state_t       state;
    logic [CNT_W-1:0]  train_cnt;
    logic              pick0;
    logic              pick1;
    logic              run_slot;

    logic [BYTE_W-1:0] ser_data_p1;
    logic              ser_vld_p1;
    grant_t            grant_p1;
    logic              active_p1;

`ifdef RR_FAIR_EN
    // Last requester granted: 0 = req0, 1 = req1. Starts at 1 so req0
    // takes the first tie.
    logic              rr_last;
`endif

    ps_phase_cnt #(
        .RATIO (RATIO)
    ) u_phase (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .last_phase (last_phase),
        .wrap       (wrap)
    );

    // Winner selection from the current valids. A lone valid requester
    // always wins; only the tie case depends on the build option.
`ifdef RR_FAIR_EN
    assign pick1 = bus.req1_valid && (!bus.req0_valid || !rr_last);
`else
    assign pick1 = bus.req1_valid && !bus.req0_valid;
`endif
    assign pick0 = bus.req0_valid && !pick1;

    // Ready is given only in the decision cycle of a RUN slot, so a byte is
    // consumed exactly when it is committed to the next slot register.
    assign run_slot       = (state == ST_RUN) && last_phase;
    assign bus.req0_ready = run_slot && pick0;
    assign bus.req1_ready = run_slot && pick1;

    // ---- slot boundary: registered lane outputs (p1) ----
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state       <= ST_TRAIN;
            train_cnt   <= '0;
            active_p1   <= 1'b0;
            ser_data_p1 <= '0;
            ser_vld_p1  <= 1'b0;
            grant_p1    <= '0;
`ifdef RR_FAIR_EN
            rr_last     <= 1'b1;
`endif
        end else begin
            // active trails the state register by one cycle.
            active_p1 <= (state == ST_RUN);
            if (last_phase) begin
                case (state)
                    ST_TRAIN: begin
                        ser_data_p1 <= COMMA;
                        ser_vld_p1  <= 1'b0;
                        grant_p1    <= '0;
                        train_cnt   <= train_cnt + CNT_W'(1);
                        if (train_cnt == CNT_W'(TRAIN_SYMS - 1)) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (pick0) begin
                            ser_data_p1 <= bus.req0_data;
                        end else if (pick1) begin
                            ser_data_p1 <= bus.req1_data;
                        end else begin
                            ser_data_p1 <= COMMA;
                        end
                        ser_vld_p1 <= pick0 || pick1;
                        grant_p1   <= grant_onehot(pick0, pick1);
`ifdef RR_FAIR_EN
                        if (pick0) begin
                            rr_last <= 1'b0;
                        end else if (pick1) begin
                            rr_last <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        state <= ST_TRAIN;
                    end
                endcase
            end
        end
    end

    assign bus.ser_load  = wrap;
    assign bus.ser_data  = ser_data_p1;
    assign bus.ser_valid = ser_vld_p1;
    assign bus.grant     = grant_p1;
    assign bus.active    = active_p1;

endmodule

// File: tb/tb_ps_link_sched.sv
// tb_ps_link_sched
//   Directed bench for ps_link_sched with RATIO=8, COMMA=8'hBC, TRAIN_SYMS=4.
//   Cycle numbering: cycle 0 is the first cycle after reset is released, so
//   the lane phase equals cyc % 8. Inputs are driven 1 time unit after the
//   rising edge; outputs are sampled there or on the falling edge.
module tb_ps_link_sched;
    import ps_link_sched_pkg::*;

    localparam int R = 8;

    logic clk_8f = 1'b0;
    logic reset  = 1'b1;
    int   cyc    = 0;
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    logic exp1;

    always #5 clk_8f = ~clk_8f;

    ps_link_sched_if bus ();

    ps_link_sched dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always @(posedge clk_8f) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk_8f);
        #1;
    endtask

    task automatic goto_cyc(input int t);
        int guard;
        guard = 0;
        while (cyc != t && guard < 500) begin
            next_cyc();
            guard++;
        end
        if (cyc != t) check_eq("goto_cyc", 32'(cyc), 32'(t));
    endtask

    task automatic check_slot(input string tag, input logic [7:0] data,
                              input logic vld, input logic [1:0] gnt);
        check_eq({tag, "_load"},  32'(bus.ser_load),  32'(1));
        check_eq({tag, "_data"},  32'(bus.ser_data),  32'(data));
        check_eq({tag, "_valid"}, 32'(bus.ser_valid), 32'(vld));
        check_eq({tag, "_grant"}, 32'(bus.grant),     32'(gnt));
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check_eq({tag, "_rdy0"}, 32'(bus.req0_ready), 32'(r0));
        check_eq({tag, "_rdy1"}, 32'(bus.req1_ready), 32'(r1));
    endtask

    // Every-cycle properties: strobe period, ready exclusivity and phase.
    always @(negedge clk_8f) begin
        if (mon_en && !reset) begin
            check_eq("load_period", 32'(bus.ser_load), 32'((cyc != 0) && (cyc % R == 0)));
            check_eq("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'(0));
            if (bus.req0_ready || bus.req1_ready)
                check_eq("ready_phase", 32'(cyc % R), 32'(R - 1));
        end
    end

    initial begin
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h00;

        // Reset held 5 cycles with both requesters asserting valid.
        repeat (5) next_cyc();
        check_eq("rst_load",   32'(bus.ser_load),   32'(0));
        check_eq("rst_data",   32'(bus.ser_data),   32'(8'h00));
        check_eq("rst_valid",  32'(bus.ser_valid),  32'(0));
        check_eq("rst_grant",  32'(bus.grant),      32'(2'b00));
        check_eq("rst_active", 32'(bus.active),     32'(0));
        check_rdy("rst", 1'b0, 1'b0);

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Training: four comma slots, then RUN.
        for (int k = 1; k <= 4; k++) begin
            goto_cyc(8 * k);
            check_slot("train", 8'hBC, 1'b0, 2'b00);
        end
        check_eq("active_c32", 32'(bus.active), 32'(0));
        goto_cyc(33);
        check_eq("active_c33", 32'(bus.active), 32'(1));

        // Lone req0: 11 then FF.
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h11;
        goto_cyc(38);
        check_rdy("t2_c38", 1'b0, 1'b0);
        goto_cyc(39);
        check_rdy("t2_c39", 1'b1, 1'b0);
        goto_cyc(40);
        check_slot("t2_s40", 8'h11, 1'b1, 2'b01);
        bus.req0_data = 8'hFF;
        goto_cyc(47);
        check_rdy("t2_c47", 1'b1, 1'b0);
        goto_cyc(48);
        check_slot("t2_s48", 8'hFF, 1'b1, 2'b01);

        // Lone req1 (5A); also leaves req1 as the last winner.
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h5A;
        goto_cyc(55);
        check_rdy("t3a_c55", 1'b0, 1'b1);
        goto_cyc(56);
        check_slot("t3a_s56", 8'h5A, 1'b1, 2'b10);

        // Both valid for 4 slots.
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hEE;
        bus.req1_data  = 8'h4E;
        for (int s = 0; s < 4; s++) begin
`ifdef RR_FAIR_EN
            exp1 = (s % 2 == 1);
`else
            exp1 = 1'b0;
`endif
            goto_cyc(63 + 8 * s);
            check_rdy("t3_tie", !exp1, exp1);
            goto_cyc(64 + 8 * s);
            check_slot("t3_slot", exp1 ? 8'h4E : 8'hEE, 1'b1, exp1 ? 2'b10 : 2'b01);
        end

        // req1 valid only during phases 0..5 of slot 88..95.
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'hA2;
        goto_cyc(94);
        bus.req1_valid = 1'b0;
        goto_cyc(95);
        check_rdy("t4_c95", 1'b0, 1'b0);
        goto_cyc(96);
        check_slot("t4_s96", 8'hBC, 1'b0, 2'b00);

        // Data slot 104 carries 77, then reset at phase 3 with 90 pending.
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h77;
        goto_cyc(104);
        check_slot("t5_s104", 8'h77, 1'b1, 2'b10);
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h90;
        goto_cyc(107);
        reset = 1'b1;
        next_cyc();
        check_eq("t5_rst_load",   32'(bus.ser_load),  32'(0));
        check_eq("t5_rst_data",   32'(bus.ser_data),  32'(8'h00));
        check_eq("t5_rst_valid",  32'(bus.ser_valid), 32'(0));
        check_eq("t5_rst_grant",  32'(bus.grant),     32'(2'b00));
        check_eq("t5_rst_active", 32'(bus.active),    32'(0));
        check_rdy("t5_rst", 1'b0, 1'b0);
        next_cyc();
        reset = 1'b0;

        goto_cyc(7);
        check_rdy("t5_train_c7", 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            goto_cyc(8 * k);
            check_slot("t5_train", 8'hBC, 1'b0, 2'b00);
        end
        goto_cyc(39);
        check_rdy("t5_c39", 1'b1, 1'b0);
        goto_cyc(40);
        check_slot("t5_s40", 8'h90, 1'b1, 2'b01);

        bus.req0_valid = 1'b0;
        goto_cyc(48);
        check_slot("t5_s48", 8'hBC, 1'b0, 2'b00);
        next_cyc();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
